cam_lut_access_arb: RTL and testbench

- Arbitrates two management requesters onto the single rd/wr management port of the unencoded CAM/LUT state machine.
- Client 0 is the host register interface; client 1 is the hardware learn/age engine.
- Grants one transaction at a time, round-robin, and holds the downstream request until it is acked.
- Returns read results and a completion pulse to the owning client, with a timeout-protected error path.

---
 rtl/cam_lut_access_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_cam_lut_access_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lut_access_arb.sv
// Round-robin arbiter placing two management clients onto the single rd/wr
// port of the CAM/LUT state machine, with ack timeout and post-transaction drain.
module cam_lut_access_arb #(
  parameter int CMP_WIDTH      = 32,
  parameter int DATA_WIDTH     = 3,
  parameter int LUT_DEPTH_BITS = 4,
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  client_req,
  input  logic [1:0]                  client_wr,
  input  logic [2*LUT_DEPTH_BITS-1:0] client_addr,
  input  logic [2*DATA_WIDTH-1:0]     client_data,
  input  logic [2*CMP_WIDTH-1:0]      client_cmp_data,
  input  logic [2*CMP_WIDTH-1:0]      client_cmp_dmask,
  output logic [1:0]                  client_ack,
  output logic                        client_err,
  output logic [DATA_WIDTH-1:0]       client_rd_data,
  output logic [CMP_WIDTH-1:0]        client_rd_cmp_data,
  output logic [CMP_WIDTH-1:0]        client_rd_cmp_dmask,
  output logic [LUT_DEPTH_BITS-1:0]   rd_addr,
  output logic                        rd_req,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  input  logic [CMP_WIDTH-1:0]        rd_cmp_data,
  input  logic [CMP_WIDTH-1:0]        rd_cmp_dmask,
  input  logic                        rd_ack,
  output logic [LUT_DEPTH_BITS-1:0]   wr_addr,
  output logic                        wr_req,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [CMP_WIDTH-1:0]        wr_cmp_data,
  output logic [CMP_WIDTH-1:0]        wr_cmp_dmask,
  input  logic                        wr_ack
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DONE, DRAIN} state_t;

  // Both counters are 8 bits; DRAIN_CYCLES must lie in 1..256.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      grant_q, grant_d;
  logic [7:0]                tmo_q, tmo_d;
  logic [7:0]                drain_q, drain_d;
  logic                      err_q, err_d;
  logic                      rd_req_q, rd_req_d;
  logic [LUT_DEPTH_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                      wr_req_q, wr_req_d;
  logic [LUT_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [CMP_WIDTH-1:0]      wr_cmp_data_q, wr_cmp_data_d;
  logic [CMP_WIDTH-1:0]      wr_cmp_dmask_q, wr_cmp_dmask_d;
  logic [1:0]                client_ack_q, client_ack_d;
  logic                      client_err_q, client_err_d;
  logic [DATA_WIDTH-1:0]     client_rd_data_q, client_rd_data_d;
  logic [CMP_WIDTH-1:0]      client_rd_cmp_data_q, client_rd_cmp_data_d;
  logic [CMP_WIDTH-1:0]      client_rd_cmp_dmask_q, client_rd_cmp_dmask_d;

  // On a tie the client that did not win last time is chosen.
  logic                      sel;
  logic                      sel_wr;
  logic [LUT_DEPTH_BITS-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic [CMP_WIDTH-1:0]      sel_cmp;
  logic [CMP_WIDTH-1:0]      sel_dmask;

  assign sel       = (client_req == 2'b11) ? ~last_grant_q : client_req[1];
  assign sel_wr    = sel ? client_wr[1] : client_wr[0];
  assign sel_addr  = sel ? client_addr[2*LUT_DEPTH_BITS-1:LUT_DEPTH_BITS]
                         : client_addr[LUT_DEPTH_BITS-1:0];
  assign sel_data  = sel ? client_data[2*DATA_WIDTH-1:DATA_WIDTH]
                         : client_data[DATA_WIDTH-1:0];
  assign sel_cmp   = sel ? client_cmp_data[2*CMP_WIDTH-1:CMP_WIDTH]
                         : client_cmp_data[CMP_WIDTH-1:0];
  assign sel_dmask = sel ? client_cmp_dmask[2*CMP_WIDTH-1:CMP_WIDTH]
                         : client_cmp_dmask[CMP_WIDTH-1:0];

  always_comb begin
    state_d               = state_q;
    last_grant_d          = last_grant_q;
    grant_d               = grant_q;
    tmo_d                 = tmo_q;
    drain_d               = drain_q;
    err_d                 = err_q;
    rd_req_d              = rd_req_q;
    rd_addr_d             = rd_addr_q;
    wr_req_d              = wr_req_q;
    wr_addr_d             = wr_addr_q;
    wr_data_d             = wr_data_q;
    wr_cmp_data_d         = wr_cmp_data_q;
    wr_cmp_dmask_d        = wr_cmp_dmask_q;
    client_ack_d          = 2'b00;
    client_err_d          = 1'b0;
    client_rd_data_d      = client_rd_data_q;
    client_rd_cmp_data_d  = client_rd_cmp_data_q;
    client_rd_cmp_dmask_d = client_rd_cmp_dmask_q;

    case (state_q)
      IDLE: begin
        if (|client_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          tmo_d        = 8'd0;
          err_d        = 1'b0;
          if (sel_wr) begin
            wr_req_d       = 1'b1;
            wr_addr_d      = sel_addr;
            wr_data_d      = sel_data;
            wr_cmp_data_d  = sel_cmp;
            wr_cmp_dmask_d = sel_dmask;
            state_d        = WR_WAIT;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = sel_addr;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rd_ack) begin
          client_rd_data_d      = rd_data;
          client_rd_cmp_data_d  = rd_cmp_data;
          client_rd_cmp_dmask_d = rd_cmp_dmask;
          rd_req_d              = 1'b0;
          state_d               = DONE;
        end else if (tmo_q == TMO_LAST) begin
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WR_WAIT: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = DONE;
        end else if (tmo_q == TMO_LAST) begin
          wr_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DONE: begin
        client_ack_d = grant_q ? 2'b10 : 2'b01;
        client_err_d = err_q;
        drain_d      = 8'd0;
        state_d      = DRAIN;
      end
      DRAIN: begin
        // Late or duplicate downstream acks are deliberately ignored here.
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q               <= IDLE;
      last_grant_q          <= 1'b1;
      grant_q               <= 1'b0;
      tmo_q                 <= 8'd0;
      drain_q               <= 8'd0;
      err_q                 <= 1'b0;
      rd_req_q              <= 1'b0;
      rd_addr_q             <= '0;
      wr_req_q              <= 1'b0;
      wr_addr_q             <= '0;
      wr_data_q             <= '0;
      wr_cmp_data_q         <= '0;
      wr_cmp_dmask_q        <= '0;
      client_ack_q          <= 2'b00;
      client_err_q          <= 1'b0;
      client_rd_data_q      <= '0;
      client_rd_cmp_data_q  <= '0;
      client_rd_cmp_dmask_q <= '0;
    end else begin
      state_q               <= state_d;
      last_grant_q          <= last_grant_d;
      grant_q               <= grant_d;
      tmo_q                 <= tmo_d;
      drain_q               <= drain_d;
      err_q                 <= err_d;
      rd_req_q              <= rd_req_d;
      rd_addr_q             <= rd_addr_d;
      wr_req_q              <= wr_req_d;
      wr_addr_q             <= wr_addr_d;
      wr_data_q             <= wr_data_d;
      wr_cmp_data_q         <= wr_cmp_data_d;
      wr_cmp_dmask_q        <= wr_cmp_dmask_d;
      client_ack_q          <= client_ack_d;
      client_err_q          <= client_err_d;
      client_rd_data_q      <= client_rd_data_d;
      client_rd_cmp_data_q  <= client_rd_cmp_data_d;
      client_rd_cmp_dmask_q <= client_rd_cmp_dmask_d;
    end
  end

  assign client_ack          = client_ack_q;
  assign client_err          = client_err_q;
  assign client_rd_data      = client_rd_data_q;
  assign client_rd_cmp_data  = client_rd_cmp_data_q;
  assign client_rd_cmp_dmask = client_rd_cmp_dmask_q;
  assign rd_addr             = rd_addr_q;
  assign rd_req              = rd_req_q;
  assign wr_addr             = wr_addr_q;
  assign wr_req              = wr_req_q;
  assign wr_data             = wr_data_q;
  assign wr_cmp_data         = wr_cmp_data_q;
  assign wr_cmp_dmask        = wr_cmp_dmask_q;

endmodule

// File: tb/tb_cam_lut_access_arb.sv
// Bench for cam_lut_access_arb: a LUT SM model answers requests, a scoreboard
// queue holds expected client completions and a monitor checks them.
module tb_cam_lut_access_arb;
  localparam int CW = 32;
  localparam int DW = 3;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      client_req = '0;
  logic [1:0]      client_wr = '0;
  logic [2*AW-1:0] client_addr = '0;
  logic [2*DW-1:0] client_data = '0;
  logic [2*CW-1:0] client_cmp_data = '0;
  logic [2*CW-1:0] client_cmp_dmask = '0;
  logic [1:0]      client_ack;
  logic            client_err;
  logic [DW-1:0]   client_rd_data;
  logic [CW-1:0]   client_rd_cmp_data;
  logic [CW-1:0]   client_rd_cmp_dmask;
  logic [AW-1:0]   rd_addr;
  logic            rd_req;
  logic [DW-1:0]   rd_data = '0;
  logic [CW-1:0]   rd_cmp_data = '0;
  logic [CW-1:0]   rd_cmp_dmask = '0;
  logic            rd_ack = 1'b0;
  logic [AW-1:0]   wr_addr;
  logic            wr_req;
  logic [DW-1:0]   wr_data;
  logic [CW-1:0]   wr_cmp_data;
  logic [CW-1:0]   wr_cmp_dmask;
  logic            wr_ack = 1'b0;

  cam_lut_access_arb #(
    .CMP_WIDTH(CW), .DATA_WIDTH(DW), .LUT_DEPTH_BITS(AW),
    .DRAIN_CYCLES(3), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .reset(reset),
    .client_req(client_req), .client_wr(client_wr), .client_addr(client_addr),
    .client_data(client_data), .client_cmp_data(client_cmp_data),
    .client_cmp_dmask(client_cmp_dmask),
    .client_ack(client_ack), .client_err(client_err),
    .client_rd_data(client_rd_data), .client_rd_cmp_data(client_rd_cmp_data),
    .client_rd_cmp_dmask(client_rd_cmp_dmask),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data),
    .rd_cmp_data(rd_cmp_data), .rd_cmp_dmask(rd_cmp_dmask), .rd_ack(rd_ack),
    .wr_addr(wr_addr), .wr_req(wr_req), .wr_data(wr_data),
    .wr_cmp_data(wr_cmp_data), .wr_cmp_dmask(wr_cmp_dmask), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic        rd;
    logic [2:0]  d;
    logic [31:0] cmp;
    logic [31:0] msk;
    logic        lat;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acks = 0;
  int last_ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // LUT SM model knobs and the write fields the model expects to see.
  int          m_delay = 1;
  int          m_repeat = 1;
  bit          m_no_ack = 1'b0;
  logic [3:0]  x_addr = '0;
  logic [2:0]  x_data = '0;
  logic [31:0] x_cmp = '0;
  logic [31:0] x_msk = '0;
  bit          x_chk = 1'b0;

  logic [DW+2*CW-1:0] mem [16];
  bit mem_ready = 1'b0;
  int cnt = 0;
  int rep_left = 0;
  bit served = 1'b0;
  bit kind_wr = 1'b0;
  bit chk_drop = 1'b0;

  always @(negedge clk) begin : lut_model
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    if (!reset) begin
      if (!mem_ready) begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1] = {3'd1, 32'h1111_1111, 32'h0000_00F1};
        mem[2] = {3'd2, 32'h2222_2222, 32'h0000_00F2};
        mem_ready = 1'b1;
      end
      cnt = 0; rep_left = 0; served = 1'b0; chk_drop = 1'b0;
    end else begin
      if (chk_drop) begin
        check("req_drop_after_ack", {62'd0, rd_req, wr_req}, 64'd0);
        chk_drop = 1'b0;
      end
      if (rep_left > 0) begin
        if (kind_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
        rep_left--;
      end else if (rd_req || wr_req) begin
        if (!served) begin
          cnt++;
          if (!m_no_ack && cnt == m_delay) begin
            served = 1'b1;
            kind_wr = wr_req;
            last_ack_cyc = cyc;
            chk_drop = 1'b1;
            if (wr_req) begin
              if (x_chk) begin
                check("wr_addr", 64'(wr_addr), 64'(x_addr));
                check("wr_data", 64'(wr_data), 64'(x_data));
                check("wr_cmp_data", 64'(wr_cmp_data), 64'(x_cmp));
                check("wr_cmp_dmask", 64'(wr_cmp_dmask), 64'(x_msk));
              end
              mem[wr_addr] = {wr_data, wr_cmp_data, wr_cmp_dmask};
              wr_ack = 1'b1;
            end else begin
              {rd_data, rd_cmp_data, rd_cmp_dmask} = mem[rd_addr];
              rd_ack = 1'b1;
            end
            rep_left = m_repeat - 1;
          end
        end
      end else begin
        if (cnt > 0 && !served) check("timeout_req_cycles", 64'(cnt), 64'd255);
        cnt = 0;
        served = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (rd_req || wr_req) check("req_overlap", {63'd0, rd_req & wr_req}, 64'd0);
      if (client_ack != 2'b00) begin
        n_acks++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'(client_ack), 64'd0);
        end else begin
          e = sb.pop_front();
          check("client_ack", 64'(client_ack), 64'(e.ack));
          check("client_err", 64'(client_err), 64'(e.err));
          if (e.rd) begin
            check("client_rd_data", 64'(client_rd_data), 64'(e.d));
            check("client_rd_cmp_data", 64'(client_rd_cmp_data), 64'(e.cmp));
            check("client_rd_cmp_dmask", 64'(client_rd_cmp_dmask), 64'(e.msk));
          end
          if (e.lat) check("ack_latency", 64'(cyc), 64'(last_ack_cyc + 2));
        end
      end
    end
  end

  task automatic issue(input int c, input bit wr, input logic [3:0] a, input logic [2:0] d,
                       input logic [31:0] cm, input logic [31:0] mk, input logic [2:0] ed,
                       input logic [31:0] ec, input logic [31:0] em, input bit err, input bit lat);
    exp_t e;
    client_wr[c] = wr;
    client_addr[c*AW +: AW] = a;
    client_data[c*DW +: DW] = d;
    client_cmp_data[c*CW +: CW] = cm;
    client_cmp_dmask[c*CW +: CW] = mk;
    if (wr) begin
      x_addr = a; x_data = d; x_cmp = cm; x_msk = mk; x_chk = 1'b1;
    end
    e.ack = (c == 1) ? 2'b10 : 2'b01;
    e.err = err; e.rd = !wr; e.d = ed; e.cmp = ec; e.msk = em; e.lat = lat;
    sb.push_back(e);
    client_req[c] = 1'b1;
  endtask

  // Clients release their request once they see their completion.
  task automatic step();
    @(negedge clk);
    client_req = client_req & ~client_ack;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      check("completion_within_budget", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (6) step();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    repeat (3) @(negedge clk);
    check("rst_client_ack", 64'(client_ack), 64'd0);
    check("rst_client_err", 64'(client_err), 64'd0);
    check("rst_reqs", {62'd0, rd_req, wr_req}, 64'd0);
    check("rst_addrs", {56'd0, rd_addr, wr_addr}, 64'd0);
    check("rst_wr_fields", {wr_data, wr_cmp_data, wr_cmp_dmask[28:0]}, 64'd0);
    check("rst_rd_fields", {client_rd_data, client_rd_cmp_data, client_rd_cmp_dmask[28:0]}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Both clients read continuously: grants must alternate 0,1,0,1,0,1.
    m_delay = 1; m_repeat = 1;
    for (int k = 0; k < 6; k++)
      issue(k % 2, 1'b0, (k % 2) ? 4'd2 : 4'd1, 3'd0, 32'd0, 32'd0,
            (k % 2) ? 3'd2 : 3'd1, (k % 2) ? 32'h2222_2222 : 32'h1111_1111,
            (k % 2) ? 32'h0000_00F2 : 32'h0000_00F1, 1'b0, 1'b1);
    base = n_acks;
    for (int i = 0; i < 300 && n_acks < base + 6; i++) @(negedge clk);
    client_req = 2'b00;
    wait_done(50);

    // Client 0 write, ack after 2 cycles.
    m_delay = 2;
    issue(0, 1'b1, 4'd5, 3'b101, 32'hA5A5_0000, 32'h0000_FFFF, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_done(50);
    x_chk = 1'b0;

    // Client 1 reads back, ack after 3 cycles.
    m_delay = 3;
    issue(1, 1'b0, 4'd5, 3'd0, 32'd0, 32'd0, 3'b101, 32'hA5A5_0000, 32'h0000_FFFF, 1'b0, 1'b1);
    wait_done(50);

    // Three consecutive rd_acks must yield a single completion.
    m_delay = 1; m_repeat = 3;
    issue(0, 1'b0, 4'd2, 3'd0, 32'd0, 32'd0, 3'd2, 32'h2222_2222, 32'h0000_00F2, 1'b0, 1'b1);
    wait_done(50);
    m_repeat = 1;

    // Write never acked: times out with err, then a normal read follows.
    m_no_ack = 1'b1;
    issue(0, 1'b1, 4'd7, 3'b011, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    wait_done(400);
    m_no_ack = 1'b0;
    issue(1, 1'b0, 4'd5, 3'd0, 32'd0, 32'd0, 3'b101, 32'hA5A5_0000, 32'h0000_FFFF, 1'b0, 1'b1);
    wait_done(50);

    // Reset asserted while waiting on a write ack.
    m_no_ack = 1'b1;
    issue(0, 1'b1, 4'd9, 3'b110, 32'h1234_5678, 32'hFFFF_0000, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (10) step();
    check("wr_req_before_reset", 64'(wr_req), 64'd1);
    reset = 1'b0;
    #1;
    check("wr_req_async_reset", 64'(wr_req), 64'd0);
    check("ack_async_reset", 64'(client_ack), 64'd0);
    sb.delete();
    client_req = 2'b00;
    m_no_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // After reset, client 0 wins the first tie again.
    issue(0, 1'b0, 4'd1, 3'd0, 32'd0, 32'd0, 3'd1, 32'h1111_1111, 32'h0000_00F1, 1'b0, 1'b1);
    issue(1, 1'b0, 4'd2, 3'd0, 32'd0, 32'd0, 3'd2, 32'h2222_2222, 32'h0000_00F2, 1'b0, 1'b1);
    wait_done(80);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
